// File: rtl/muldiv_unit.sv
// Shared iterative multiply/divide engine for the multicycle CPU datapath.
// Shift-add multiply and restoring divide run on sign-stripped magnitudes.
// Signs are reapplied in a final fix-up cycle that writes the HI/LO pair.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;        // product accumulator or {remainder, quotient}
  logic [WIDTH-1:0]   operand;    // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_res;    // product / quotient must be negated
  logic               neg_rem;    // remainder must be negated
  logic               zero_flag;

  // Operand sign handling at start time; op[0]=1 selects the unsigned ops.
  logic             is_signed_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             b_is_zero;

  assign is_signed_in = ~op[0];
  assign a_neg        = is_signed_in & a[WIDTH-1];
  assign b_neg        = is_signed_in & b[WIDTH-1];
  assign a_mag        = a_neg ? (~a + 1'b1) : a;
  assign b_mag        = b_neg ? (~b + 1'b1) : b;
  assign b_is_zero    = (b == {WIDTH{1'b0}});

  // One iteration step of either algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
  assign div_next = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up of the finished magnitudes.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: divide by zero skips the iterations entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (op[1] && b_is_zero) ? FIX : ITER;
      ITER: if (count == CW'(1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and the registered result pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      operand   <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      zero_flag <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count     <= CW'(WIDTH);
            is_div    <= op[1];
            neg_res   <= a_neg ^ b_neg;
            neg_rem   <= a_neg;
            zero_flag <= op[1] & b_is_zero;
            if (op[1]) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              operand <= b_mag;
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_mag};
              operand <= a_mag;
            end
          end
        end
        ITER: begin
          count <= count - 1'b1;
          acc   <= is_div ? div_next : mul_next;
        end
        FIX: begin
          done     <= 1'b1;
          div_zero <= zero_flag;
          if (!zero_flag) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
